// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants and types for the ECDSA front end
package ecc_pkg;
   localparam logic [255:0] CURVE_N_DEFAULT =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
   localparam int KEY_BYTES   = 32;
   localparam int MSG_BYTES   = 12;
   localparam int FRAME_BYTES = KEY_BYTES + MSG_BYTES;
   typedef enum logic [1:0] {LOAD, CHECK, START, WAIT_DONE} loader_state_t;
endpackage

// File: rtl/key_range_check.sv
// key_range_check: flags a scalar outside [1, n-1]
module key_range_check (
   input  logic [255:0] key,
   input  logic [255:0] n,
   output logic         bad
);
   assign bad = (key == '0) || (key >= n);
endmodule

// File: rtl/ecc_input_loader.sv
// ecc_input_loader: assembles key and message from a byte stream and launches the signing core
module ecc_input_loader import ecc_pkg::*; #(
   parameter logic [255:0] CURVE_N = CURVE_N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         Done,
   output logic [255:0] priv_key,
   output logic [95:0]  message,
   output logic         start,
   output logic         invalid_error
);
   loader_state_t state, state_nxt;
   logic [5:0] cnt;
   logic       bad;
   logic       take;
   logic       last;
   key_range_check u_range (.key(priv_key), .n(CURVE_N), .bad(bad));
   assign take = in_valid && in_ready && !clear;
   assign last = cnt == 6'(FRAME_BYTES - 1);
   always_ff @(posedge clk)
      if (!reset_n) state <= LOAD;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD:      if (take && last) state_nxt = CHECK;
         CHECK:     state_nxt = bad ? LOAD : START;
         START:     state_nxt = WAIT_DONE;
         WAIT_DONE: if (Done) state_nxt = LOAD;
      endcase
   end
   always_comb begin
      in_ready = state == LOAD;
      start    = state == START;
   end
   // cnt parks at the last index until CHECK or Done clears it
   always_ff @(posedge clk)
      if (!reset_n) begin
         cnt           <= '0;
         priv_key      <= '0;
         message       <= '0;
         invalid_error <= 1'b0;
      end else if (state == LOAD && clear) begin
         cnt      <= '0;
         priv_key <= '0;
         message  <= '0;
      end else if (take) begin
         if (cnt < 6'(KEY_BYTES)) priv_key <= {priv_key[247:0], in_data};
         else message <= {message[87:0], in_data};
         if (!last) cnt <= cnt + 6'd1;
         if (cnt == '0) invalid_error <= 1'b0;
      end else if (state == CHECK && bad) begin
         invalid_error <= 1'b1;
         cnt           <= '0;
      end else if (state == WAIT_DONE && Done) cnt <= '0;
endmodule

// File: tb/tb_ecc_input_loader.sv
// tb_ecc_input_loader: frame-level checks of the ECDSA input loader
module tb_ecc_input_loader;
   localparam logic [255:0] N =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
   typedef struct {
      logic [255:0] key;
      logic [95:0]  msg;
      bit           bad;
      int           gap;
      bit           junk;
      int           dly;
      bit           early;
   } vec_t;
   logic clk = 0, reset_n = 0, clear = 0, in_valid = 0, Done = 0;
   logic [7:0] in_data = 0;
   logic in_ready, start, invalid_error;
   logic [255:0] priv_key;
   logic [95:0]  message;
   int n_vec = 0, n_err = 0, starts = 0;
   bit last_bad = 0;
   vec_t tbl[7];
   ecc_input_loader dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .Done(Done),
      .priv_key(priv_key), .message(message), .start(start),
      .invalid_error(invalid_error)
   );
   always #10 clk = ~clk;
   always @(negedge clk) if (start === 1'b1) starts++;
   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   task automatic tick;
      @(negedge clk);
   endtask
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic run_frame(input logic [255:0] key, input logic [95:0] msg, input bit bad,
                            input int gap, input bit junk, input int dly, input bit early,
                            input bit prev_bad);
      logic [7:0] b[44];
      int s0;
      for (int i = 0; i < 44; i++)
         b[i] = i < 32 ? key[255-8*i -: 8] : msg[95-8*(i-32) -: 8];
      #2 s0 = starts;
      chk("err_held", {255'd0, invalid_error}, {255'd0, prev_bad});
      if (early) Done = 1;
      for (int i = 0; i < 44; i++) begin
         chk("ready_load", {255'd0, in_ready}, 1);
         for (int g = 0; g < 20 && $urandom_range(99) < gap; g++) begin
            in_valid = 0;
            in_data = 8'($urandom);
            tick;
            chk("ready_gap", {255'd0, in_ready}, 1);
         end
         in_valid = 1;
         in_data = b[i];
         tick;
         if (i == 0) chk("err_clear", {255'd0, invalid_error}, 0);
      end
      in_valid = junk;
      in_data = 8'($urandom);
      chk("ready_check", {255'd0, in_ready}, 0);
      chk("start_check", {255'd0, start}, 0);
      chk("key", priv_key, key);
      chk("msg", {160'd0, message}, {160'd0, msg});
      tick;
      if (bad) begin
         in_valid = 0;
         chk("err_set", {255'd0, invalid_error}, 1);
         chk("ready_retry", {255'd0, in_ready}, 1);
         chk("start_bad", {255'd0, start}, 0);
      end else begin
         chk("start_pulse", {255'd0, start}, 1);
         chk("ready_start", {255'd0, in_ready}, 0);
         chk("err_ok", {255'd0, invalid_error}, 0);
         if (early) begin
            in_valid = 0;
            tick;
            chk("ready_wait", {255'd0, in_ready}, 0);
            chk("start_once", {255'd0, start}, 0);
            tick;
            chk("ready_done", {255'd0, in_ready}, 1);
            Done = 0;
         end else if (dly < 0) begin
            in_valid = 0;
         end else begin
            for (int d = 0; d < dly; d++) begin
               in_data = 8'($urandom);
               tick;
               chk("ready_wait", {255'd0, in_ready}, 0);
               chk("start_once", {255'd0, start}, 0);
               chk("key_hold", priv_key, key);
            end
            Done = 1;
            in_valid = 0;
            tick;
            chk("ready_done", {255'd0, in_ready}, 1);
            Done = 0;
         end
      end
      #2 chk("start_count", 256'(starts - s0), bad ? 0 : 1);
   endtask
   task automatic chk_reset;
      chk("rst_ready", {255'd0, in_ready}, 1);
      chk("rst_start", {255'd0, start}, 0);
      chk("rst_key", priv_key, 0);
      chk("rst_msg", {160'd0, message}, 0);
      chk("rst_err", {255'd0, invalid_error}, 0);
   endtask
   initial begin
      logic [255:0] k;
      logic [95:0]  m;
      bit bad;
      int s0;
      tbl[0] = '{256'd1, 96'hece498ece498ece498ece498, 0, 0, 0, 20, 0};
      tbl[1] = '{256'd0, 96'h0123456789abcdef01234567, 1, 0, 0, 20, 0};
      tbl[2] = '{N, 96'hfedcba9876543210fedcba98, 1, 10, 0, 20, 0};
      tbl[3] = '{N - 256'd1, 96'h5a5a5a5a5a5a5a5a5a5a5a5a, 0, 0, 1, 5, 0};
      tbl[4] = '{{256{1'b1}}, 96'h111111111111111111111111, 1, 30, 1, 5, 0};
      tbl[5] = '{256'd1 << 255, 96'hffffffffffffffffffffffff, 0, 20, 1, 1, 0};
      tbl[6] = '{N - 256'd1, 96'h0badc0de0badc0de0badc0de, 0, 0, 0, 0, 1};
      repeat (3) tick;
      reset_n = 1;
      tick;
      chk_reset;
      foreach (tbl[i]) begin
         run_frame(tbl[i].key, tbl[i].msg, tbl[i].bad, tbl[i].gap, tbl[i].junk,
                   tbl[i].dly, tbl[i].early, last_bad);
         last_bad = tbl[i].bad;
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1;
         in_data = 8'($urandom);
         tick;
      end
      clear = 1;
      in_data = 8'hAA;
      tick;
      clear = 0;
      in_valid = 0;
      chk("clr_key", priv_key, 0);
      chk("clr_msg", {160'd0, message}, 0);
      chk("clr_ready", {255'd0, in_ready}, 1);
      run_frame(256'h00c0ffee, 96'hdeadbeefcafef00d12345678, 0, 0, 0, 3, 0, 0);
      run_frame(256'h1234, 96'habc, 0, 15, 1, -1, 0, 0);
      #2 s0 = starts;
      reset_n = 0;
      Done = 1;
      in_valid = 1;
      tick;
      reset_n = 1;
      Done = 0;
      in_valid = 0;
      chk_reset;
      tick;
      chk("rst_idle_ready", {255'd0, in_ready}, 1);
      #2 chk("rst_no_start", 256'(starts - s0), 0);
      last_bad = 0;
      for (int r = 0; r < 10; r++) begin
         case ($urandom_range(5))
            0: k = '0;
            1: k = N;
            2: k = N - 256'd1;
            3: k = N + 256'($urandom_range(1, 1000));
            default: k = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
         endcase
         m = {$urandom, $urandom, $urandom};
         bad = k == 0 || k >= N;
         run_frame(k, m, bad, $urandom_range(0, 60), 1'($urandom_range(1)),
                   $urandom_range(1, 30), 0, last_bad);
         last_bad = bad;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ecc_input_loader.md
# ecc_input_loader

Upstream front end for the ECDSA signing top level (`final_top`). It accepts a byte stream on a valid/ready interface and assembles the 256-bit private key and 96-bit message. It range-checks the key against the curve order, issues a single-cycle start to the signing core, and then holds off new input until the core reports `Done`.

## Interface
Parameters:
- `CURVE_N`, default 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141. Curve group order; a valid key lies in [1, N-1].

Ports:
- `clk`  in  1  system clock, 50 MHz; all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `clear`  in  1  synchronous abort of a partial frame.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte.
- `Done`  in  1  signing core finished; driven by `final_top`.
- `priv_key`  out  256  assembled key, to `final_top`.
- `message`  out  96  assembled message, to `final_top`.
- `start`  out  1  single-cycle launch pulse to the core.
- `invalid_error`  out  1  key out of range; sticky.

## Operation
- Frame is 44 bytes: 32 key bytes, then 12 message bytes, each sent most-significant byte first. Bytes shift in from the LSB side.
- A byte is accepted on any cycle where `in_valid && in_ready`. Gaps in `in_valid` are legal.
- Byte counter `cnt` is 6 bits wide and runs 0..43. It never wraps: when the 44th byte is accepted the FSM leaves LOAD.
- Key bytes shift into `priv_key` and message bytes shift into `message`. Routing is selected by `cnt < 32`.
- FSM states and transitions:
  - LOAD: `in_ready`=1. Go to CHECK when the byte with `cnt`=43 is accepted.
  - CHECK: `in_ready`=0. Evaluate `bad = (priv_key == 0) || (priv_key >= CURVE_N)`.
    - If `bad`: set `invalid_error`, clear `cnt`, go to LOAD.
    - Otherwise: go to START.
  - START: `start`=1 for exactly one cycle, then go to WAIT_DONE.
  - WAIT_DONE: `in_ready`=0. On `Done`=1, clear `cnt` and go to LOAD.
- `Done` is sampled only in WAIT_DONE. A `Done` that is high during START, or that is still high from a previous run, is ignored until WAIT_DONE is entered.
- `invalid_error` is cleared when the first byte of the next frame is accepted (`cnt`=0).
- `clear`:
  - In LOAD: zero `cnt`, `priv_key` and `message`. Any byte offered in the same cycle is dropped, because `clear` has priority.
  - In CHECK, START or WAIT_DONE: ignored. An issued launch cannot be aborted by `clear`.
- `priv_key` and `message` stay stable from CHECK through WAIT_DONE.

## Timing
- Reset values:
  - state LOAD, `cnt` 0.
  - `priv_key` 0, `message` 0, `start` 0, `invalid_error` 0.
  - `in_ready` 1 from the first cycle after reset.
- Reset mid-frame or in WAIT_DONE returns to the reset state next cycle. Any pending `Done` is discarded.
- Last byte accepted at edge T:
  - CHECK during cycle T+1.
  - `start` high during T+2 for a valid key.
  - For an invalid key, `invalid_error` is high from T+2 and `in_ready` is high at T+2.
- Minimum frame-to-start latency is 46 cycles (44 bytes plus 2).
- `in_ready` is a registered function of state only. It does not depend combinationally on `in_valid`.

## Structure
- Shared package `ecc_pkg` holds:
  - `CURVE_N` default value.
  - `KEY_BYTES`=32, `MSG_BYTES`=12, `FRAME_BYTES`=44.
  - `loader_state_t` enum {LOAD, CHECK, START, WAIT_DONE}.
- Sub-module `key_range_check`: purely combinational. Takes 256-bit key and N, outputs `bad`. It is reused later by the signature validity stage.

## Test plan
- Valid frame:
  - Stimulus: key 0x00…01, message 96'hece498ece498ece498ece498, streamed back-to-back; `Done` pulsed 20 cycles after `start`.
  - Required: `start` one cycle at T+2; outputs equal the loaded values; `in_ready` returns to 1 after `Done`.
- Range boundaries:
  - Stimulus: key 0, key equal to `CURVE_N`, key `CURVE_N`-1.
  - Required: the first two set `invalid_error` with no `start`; the third produces `start`.
  - Required: `invalid_error` clears on the first byte of the next frame.
- Backpressure and gaps:
  - Stimulus: random `in_valid` gaps; bytes also offered during WAIT_DONE.
  - Required: no byte accepted while `in_ready`=0; assembled values match the byte-exact model.
- Clear mid-frame:
  - Stimulus: `clear` after 10 bytes, with `in_valid` high in the same cycle, then a full valid frame.
  - Required: the first 10 bytes and the clear-cycle byte are discarded; the final key and message match the second frame.
- Early and late `Done`:
  - Stimulus: `Done` held high before and during START.
  - Required: exactly one `start`; FSM leaves WAIT_DONE on the first cycle after START, not earlier.
- Reset in WAIT_DONE:
  - Stimulus: assert `reset_n`=0 for one cycle.
  - Required: all outputs at reset values next cycle; no `start`.
